wb_load_queue: RTL and testbench

Parametrised writeback stage for the AXI-based CPU. It accepts in-order writeback entries from the memory-access stage and holds them in a small queue while their load data returns over the data-memory read channel. It aligns and sign- or zero-extends the returned data, then retires one register write per cycle to the register file in program order. Flush support drops responses that belong to squashed loads.

---
 rtl/wb_load_queue_pkg.sv | 23 ++
 rtl/wb_load_queue_load_align.sv | 49 ++++
 rtl/wb_load_queue.sv | 182 ++++++++++++++++++
 tb/tb_wb_load_queue.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_load_queue_pkg.sv
// Shared encodings and defaults for the writeback load queue and its
// load-alignment helper.
package wb_load_queue_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  localparam int   DATA_W_DEF = 32;
  localparam logic RST_ACTIVE = 1'b1;

  // Number of significant bits delivered by an access of the given size.
  function automatic int size_bits(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_bits = 8;
      SZ_HALF: size_bits = 16;
      SZ_WORD: size_bits = 32;
      default: size_bits = 64;
    endcase
  endfunction

endpackage

// File: rtl/wb_load_queue_load_align.sv
// Combinational lane select and sign/zero extension of returned load data.
// The offset is forced to the natural alignment of the access size.
module load_align
  import wb_load_queue_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0]           data,
  input  logic [1:0]                  size,
  input  logic                        uns,
  input  logic [$clog2(DATA_W/8)-1:0] off,
  output logic [DATA_W-1:0]           result
);

  localparam int OW = $clog2(DATA_W/8);

  logic [OW-1:0]     eff_off;
  logic [DATA_W-1:0] lane;
  logic              sign;
  int                lane_w;

  always_comb begin
    eff_off = off;
    if (size == SZ_HALF) begin
      eff_off[0] = 1'b0;
    end else if (size == SZ_WORD) begin
      eff_off[1:0] = 2'b00;
    end else if (size == SZ_DWORD) begin
      eff_off = '0;
    end

    lane   = data >> {eff_off, 3'b000};
    lane_w = size_bits(size);

    case (size)
      SZ_BYTE: sign = lane[7];
      SZ_HALF: sign = lane[15];
      SZ_WORD: sign = lane[31];
      default: sign = lane[DATA_W-1];
    endcase

    // Accesses as wide as the datapath fall through untouched.
    result = lane;
    for (int i = 0; i < DATA_W; i++) begin
      result[i] = (i < lane_w) ? lane[i] : (sign & ~uns);
    end
  end

endmodule

// File: rtl/wb_load_queue.sv
// In-order writeback queue: holds entries until their load data returns,
// aligns it, and retires one register write per cycle in program order.
module wb_load_queue
  import wb_load_queue_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 2,
  parameter int REG_AW = 5,
  parameter int PC_W   = 32
) (
  input  logic                        cpu_clk_50M,
  input  logic                        cpu_rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [REG_AW-1:0]           req_wa,
  input  logic                        req_wreg,
  input  logic                        req_mreg,
  input  logic [1:0]                  req_size,
  input  logic                        req_unsigned,
  input  logic [$clog2(DATA_W/8)-1:0] req_off,
  input  logic [DATA_W-1:0]           req_dreg,
  input  logic [PC_W-1:0]             req_pc,
  input  logic                        flush,
  input  logic                        mem_data_ok,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        wb_valid,
  output logic [REG_AW-1:0]           wb_wa,
  output logic                        wb_wreg,
  output logic [DATA_W-1:0]           wb_wd,
  output logic [PC_W-1:0]             wb_pc,
  output logic                        busy,
  output logic                        proto_err
);

  localparam int OW = $clog2(DATA_W/8);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] DROP_MAX = CW'(2 * DEPTH - 1);

  // Entry storage, indexed by circular pointer.
  logic [REG_AW-1:0] q_wa     [DEPTH];
  logic              q_wreg   [DEPTH];
  logic              q_mreg   [DEPTH];
  logic [1:0]        q_size   [DEPTH];
  logic              q_uns    [DEPTH];
  logic [OW-1:0]     q_off    [DEPTH];
  logic [DATA_W-1:0] q_dreg   [DEPTH];
  logic [PC_W-1:0]   q_pc     [DEPTH];
  logic [DATA_W-1:0] q_data   [DEPTH];
  logic              q_dvalid [DEPTH];

  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [CW-1:0] drop_cnt, drop_nxt;
  logic          proto_nxt;

  logic          ld_found;
  logic [PW-1:0] ld_idx, scan_idx;
  logic [CW-1:0] n_pend;
  logic [CW:0]   drop_sum;

  logic              push, retire, take_data, fwd;
  logic [DATA_W-1:0] align_in, align_out;

  // Request handshake: an entry is accepted on a cycle where req_valid and
  // req_ready are both high and flush is low; req_ready depends only on the
  // fill level, so a full queue refuses even if the head retires that cycle.
  assign req_ready = (count != FULL_CNT);
  assign busy      = (count != '0) || (drop_cnt != '0);

  // Oldest load still waiting for data, and how many loads are waiting.
  always_comb begin
    ld_found = 1'b0;
    ld_idx   = head;
    scan_idx = head;
    n_pend   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head + PW'(i);
      if ((CW'(i) < count) && q_mreg[scan_idx] && !q_dvalid[scan_idx]) begin
        if (!ld_found) begin
          ld_found = 1'b1;
          ld_idx   = scan_idx;
        end
        n_pend = n_pend + CW'(1);
      end
    end
  end

  assign take_data = !flush && mem_data_ok && (drop_cnt == '0) && ld_found;
  assign fwd       = take_data && (ld_idx == head);
  assign retire    = !flush && (count != '0) &&
                     (!q_mreg[head] || q_dvalid[head] || fwd);
  assign push      = req_valid && req_ready && !flush;

  assign align_in = fwd ? mem_rdata : q_data[head];

  load_align #(.DATA_W(DATA_W)) u_align (
    .data   (align_in),
    .size   (q_size[head]),
    .uns    (q_uns[head]),
    .off    (q_off[head]),
    .result (align_out)
  );

  // Responses owed to squashed loads are swallowed before any live load.
  always_comb begin
    drop_nxt  = drop_cnt;
    proto_nxt = proto_err;
    drop_sum  = {1'b0, drop_cnt} + {1'b0, n_pend};
    if (flush) begin
      if (mem_data_ok) begin
        if (drop_sum != '0) begin
          drop_sum = drop_sum - (CW+1)'(1);
        end else begin
          proto_nxt = 1'b1;
        end
      end
      drop_nxt = (drop_sum > {1'b0, DROP_MAX}) ? DROP_MAX : drop_sum[CW-1:0];
    end else if (mem_data_ok) begin
      if (drop_cnt != '0) begin
        drop_nxt = drop_cnt - CW'(1);
      end else if (!ld_found) begin
        proto_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst == RST_ACTIVE) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      drop_cnt  <= '0;
      proto_err <= 1'b0;
      wb_valid  <= 1'b0;
      wb_wa     <= '0;
      wb_wreg   <= 1'b0;
      wb_wd     <= '0;
      wb_pc     <= '0;
    end else begin
      drop_cnt  <= drop_nxt;
      proto_err <= proto_nxt;
      wb_valid  <= retire;
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push)   tail <= tail + PW'(1);
        if (retire) head <= head + PW'(1);
        count <= count + CW'(push) - CW'(retire);
      end
      if (retire) begin
        wb_wa   <= q_wa[head];
        wb_wreg <= q_wreg[head];
        wb_wd   <= q_mreg[head] ? align_out : q_dreg[head];
        wb_pc   <= q_pc[head];
      end
    end
  end

  // Payload needs no reset: every field is written before it is read.
  always_ff @(posedge cpu_clk_50M) begin
    if (push) begin
      q_wa[tail]     <= req_wa;
      q_wreg[tail]   <= req_wreg;
      q_mreg[tail]   <= req_mreg;
      q_size[tail]   <= req_size;
      q_uns[tail]    <= req_unsigned;
      q_off[tail]    <= req_off;
      q_dreg[tail]   <= req_dreg;
      q_pc[tail]     <= req_pc;
      q_dvalid[tail] <= 1'b0;
    end
    if (take_data) begin
      q_data[ld_idx]   <= mem_rdata;
      q_dvalid[ld_idx] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_load_queue.sv
// Randomised and directed bench for wb_load_queue with a queue-level
// reference model and a scoreboard monitor.
module tb_wb_load_queue;
  import wb_load_queue_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int AW    = 5;
  localparam int PCW   = 32;
  localparam int EW    = AW + 1 + DW + PCW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          rst, req_valid, req_ready, req_wreg, req_mreg, req_unsigned;
  logic [AW-1:0] req_wa;
  logic [1:0]    req_size, req_off;
  logic [DW-1:0] req_dreg, mem_rdata, wb_wd;
  logic [PCW-1:0] req_pc, wb_pc;
  logic          flush, mem_data_ok, wb_valid, wb_wreg, busy, proto_err;
  logic [AW-1:0] wb_wa;

  wb_load_queue #(.DATA_W(DW), .DEPTH(DEPTH), .REG_AW(AW), .PC_W(PCW)) u_dut (
    .cpu_clk_50M(clk), .cpu_rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wa(req_wa),
    .req_wreg(req_wreg), .req_mreg(req_mreg), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_off(req_off), .req_dreg(req_dreg),
    .req_pc(req_pc), .flush(flush), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_wa(wb_wa),
    .wb_wreg(wb_wreg), .wb_wd(wb_wd), .wb_pc(wb_pc), .busy(busy),
    .proto_err(proto_err)
  );

  // 64-bit datapath instance for the wide alignment cases.
  logic          x_rst, x_valid, x_ready, x_wreg, x_mreg, x_uns, x_flush, x_dok;
  logic          x_wb_valid, x_wb_wreg, x_busy, x_proto;
  logic [AW-1:0] x_wa, x_wb_wa;
  logic [1:0]    x_size;
  logic [2:0]    x_off;
  logic [63:0]   x_dreg, x_rdata, x_wb_wd;
  logic [PCW-1:0] x_pc, x_wb_pc;

  wb_load_queue #(.DATA_W(64), .DEPTH(DEPTH), .REG_AW(AW), .PC_W(PCW)) u_dut64 (
    .cpu_clk_50M(clk), .cpu_rst(x_rst),
    .req_valid(x_valid), .req_ready(x_ready), .req_wa(x_wa),
    .req_wreg(x_wreg), .req_mreg(x_mreg), .req_size(x_size),
    .req_unsigned(x_uns), .req_off(x_off), .req_dreg(x_dreg),
    .req_pc(x_pc), .flush(x_flush), .mem_data_ok(x_dok),
    .mem_rdata(x_rdata), .wb_valid(x_wb_valid), .wb_wa(x_wb_wa),
    .wb_wreg(x_wb_wreg), .wb_wd(x_wb_wd), .wb_pc(x_wb_pc), .busy(x_busy),
    .proto_err(x_proto)
  );

  // ---------------- checking helpers ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference alignment from the size/offset rules using plain arithmetic.
  function automatic logic [63:0] ref_align(input logic [63:0] d, input int w,
                                            input int size, input logic uns, input int off);
    int nbytes, eo, bits;
    logic [63:0] v, mask;
    nbytes = 1 << size;
    eo     = off - (off % nbytes);
    bits   = 8 * nbytes;
    if (bits >= w) return d;
    v    = d >> (8 * eo);
    mask = (64'd1 << bits) - 64'd1;
    v    = v & mask;
    if (!uns && v[bits-1]) v = v | ~mask;
    if (w == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    return v;
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    logic [AW-1:0]  wa;
    logic           wreg;
    logic           mreg;
    logic [1:0]     size;
    logic           uns;
    logic [1:0]     off;
    logic [DW-1:0]  dreg;
    logic [PCW-1:0] pc;
    logic [DW-1:0]  data;
    logic           have;
  } ment_t;

  ment_t          mq[$];
  int             m_drop  = 0;
  logic           m_proto = 1'b0;
  logic           m_valid = 1'b0;
  logic           m_zero  = 1'b0;
  logic [EW-1:0]  exp_q[$];
  int             exp_cyc_q[$];

  function automatic int m_unfilled();
    int n = 0;
    foreach (mq[i]) if (mq[i].mreg && !mq[i].have) n++;
    return n;
  endfunction

  function automatic ment_t mk(input int wa, input logic wreg, input logic mreg,
                               input int size, input logic uns, input int off,
                               input logic [DW-1:0] dreg, input logic [PCW-1:0] pc);
    ment_t e;
    e.wa = AW'(wa); e.wreg = wreg; e.mreg = mreg; e.size = 2'(size);
    e.uns = uns; e.off = 2'(off); e.dreg = dreg; e.pc = pc;
    e.data = '0; e.have = 1'b0;
    return e;
  endfunction

  // Advance the model by the clock edge that follows the applied inputs.
  task automatic m_step(input logic r, input logic rv, input ment_t e,
                        input logic fl, input logic dok, input logic [DW-1:0] rd);
    logic  room, found;
    ment_t h, t;
    logic [DW-1:0] wd;
    if (r) begin
      mq.delete();
      m_drop = 0; m_proto = 1'b0; m_valid = 1'b1; m_zero = 1'b1;
      return;
    end
    m_zero = 1'b0;
    if (fl) begin
      m_drop = m_drop + m_unfilled();
      if (dok) begin
        if (m_drop > 0) m_drop--; else m_proto = 1'b1;
      end
      mq.delete();
      return;
    end
    room = (mq.size() < DEPTH);
    if (dok) begin
      if (m_drop > 0) begin
        m_drop--;
      end else begin
        found = 1'b0;
        foreach (mq[i]) begin
          if (!found && mq[i].mreg && !mq[i].have) begin
            t = mq[i]; t.data = rd; t.have = 1'b1; mq[i] = t;
            found = 1'b1;
          end
        end
        if (!found) m_proto = 1'b1;
      end
    end
    if (mq.size() > 0 && (!mq[0].mreg || mq[0].have)) begin
      h  = mq.pop_front();
      wd = h.mreg ? DW'(ref_align(64'(h.data), DW, int'(h.size), h.uns, int'(h.off))) : h.dreg;
      exp_q.push_back({h.wa, h.wreg, wd, h.pc});
      exp_cyc_q.push_back(cyc + 1);
    end
    if (rv && room) mq.push_back(e);
  endtask

  // ---------------- driver ----------------
  ment_t nil_e;

  task automatic drive(input logic r, input logic rv, input ment_t e,
                       input logic fl, input logic dok, input logic [DW-1:0] rd);
    @(negedge clk);
    rst = r; req_valid = rv; req_wa = e.wa; req_wreg = e.wreg; req_mreg = e.mreg;
    req_size = e.size; req_unsigned = e.uns; req_off = e.off; req_dreg = e.dreg;
    req_pc = e.pc; flush = fl; mem_data_ok = dok; mem_rdata = rd;
    m_step(r, rv, e, fl, dok, rd);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, nil_e, 1'b0, 1'b0, '0);
  endtask

  task automatic expect_wb(input string name, input int wa, input logic [DW-1:0] wd);
    @(posedge clk); #2;
    chk({name, "_valid"}, wb_valid, 1'b1);
    chk({name, "_wa"}, wb_wa, AW'(wa));
    chk({name, "_wd"}, wb_wd, wd);
  endtask

  task automatic x_load(input string name, input int size, input logic uns, input int off,
                        input logic [63:0] rd, input logic [63:0] exp);
    @(negedge clk);
    x_valid = 1'b1; x_wa = 5'd3; x_wreg = 1'b1; x_mreg = 1'b1; x_size = 2'(size);
    x_uns = uns; x_off = 3'(off); x_pc = 32'h200; x_dok = 1'b0;
    @(negedge clk);
    x_valid = 1'b0; x_dok = 1'b1; x_rdata = rd;
    @(posedge clk); #2;
    chk({name, "_valid"}, x_wb_valid, 1'b1);
    chk({name, "_wd"}, x_wb_wd, exp);
    @(negedge clk);
    x_dok = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    logic [EW-1:0] e;
    int c;
    #1;
    if (m_valid) begin
      chk("req_ready", req_ready, mq.size() < DEPTH);
      chk("busy", busy, (mq.size() > 0) || (m_drop > 0));
      chk("proto_err", proto_err, m_proto);
      if (m_zero) chk("reset_outs", {wb_valid, wb_wa, wb_wreg, wb_wd, wb_pc}, '0);
      if (wb_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL wb_unexpected: got retire wa=%0d wd=%0h expected none (cycle %0d)",
                   wb_wa, wb_wd, cyc);
        end else begin
          e = exp_q.pop_front();
          c = exp_cyc_q.pop_front();
          chk("wb_fields", {wb_wa, wb_wreg, wb_wd, wb_pc}, e);
          chk("wb_cycle", cyc, c);
        end
      end else if (wb_valid !== 1'b0) begin
        chk("wb_valid_known", wb_valid, 1'b0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    logic fl, dok;
    nil_e = mk(0, 0, 0, 0, 0, 0, '0, '0);
    rst = 1'b1; req_valid = 1'b0; req_wa = '0; req_wreg = 1'b0; req_mreg = 1'b0;
    req_size = '0; req_unsigned = 1'b0; req_off = '0; req_dreg = '0; req_pc = '0;
    flush = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
    x_rst = 1'b1; x_valid = 1'b0; x_wa = '0; x_wreg = 1'b0; x_mreg = 1'b0;
    x_size = '0; x_uns = 1'b0; x_off = '0; x_dreg = '0; x_pc = '0;
    x_flush = 1'b0; x_dok = 1'b0; x_rdata = '0;

    drive(1'b1, 1'b0, nil_e, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, nil_e, 1'b0, 1'b0, '0);
    x_rst = 1'b0;

    // Byte and half alignment
    drive(1'b0, 1'b1, mk(1, 1, 1, 0, 0, 3, '0, 32'h100), 1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, nil_e, 1'b0, 1'b1, 32'h80FF1234);
    expect_wb("lb", 1, 32'hFFFFFF80);
    drive(1'b0, 1'b1, mk(2, 1, 1, 0, 1, 3, '0, 32'h104), 1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, nil_e, 1'b0, 1'b1, 32'h80FF1234);
    expect_wb("lbu", 2, 32'h00000080);
    drive(1'b0, 1'b1, mk(3, 1, 1, 1, 1, 2, '0, 32'h108), 1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, nil_e, 1'b0, 1'b1, 32'hBEEF0000);
    expect_wb("lhu", 3, 32'h0000BEEF);
    drive(1'b0, 1'b1, mk(3, 1, 1, 1, 0, 3, '0, 32'h10C), 1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, nil_e, 1'b0, 1'b1, 32'hBEEF0000);
    expect_wb("lh_off3", 3, 32'hFFFFBEEF);

    // Non-load behind a pending load waits its turn
    drive(1'b0, 1'b1, mk(4, 1, 1, 2, 0, 0, '0, 32'h110), 1'b0, 1'b0, '0);
    drive(1'b0, 1'b1, mk(5, 1, 0, 2, 0, 0, 32'h5, 32'h114), 1'b0, 1'b0, '0);
    idle();
    idle();
    drive(1'b0, 1'b0, nil_e, 1'b0, 1'b1, 32'h11);
    expect_wb("ord_load", 4, 32'h11);
    idle();
    expect_wb("ord_alu", 5, 32'h5);

    // Full queue, then flush with two squashed loads outstanding
    drive(1'b0, 1'b1, mk(6, 1, 1, 2, 0, 0, '0, 32'h120), 1'b0, 1'b0, '0);
    drive(1'b0, 1'b1, mk(7, 1, 1, 2, 0, 0, '0, 32'h124), 1'b0, 1'b0, '0);
    @(posedge clk); #2;
    chk("full_ready", req_ready, 1'b0);
    drive(1'b0, 1'b0, nil_e, 1'b1, 1'b0, '0);
    @(posedge clk); #2;
    chk("flush_ready", req_ready, 1'b1);
    chk("flush_busy", busy, 1'b1);
    drive(1'b0, 1'b1, mk(8, 1, 1, 2, 0, 0, '0, 32'h128), 1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, nil_e, 1'b0, 1'b1, 32'hAAAA0001);
    drive(1'b0, 1'b0, nil_e, 1'b0, 1'b1, 32'hBBBB0002);
    drive(1'b0, 1'b0, nil_e, 1'b0, 1'b1, 32'hCCCC0003);
    expect_wb("flush_c", 8, 32'hCCCC0003);

    // Stray response
    drive(1'b0, 1'b0, nil_e, 1'b0, 1'b1, 32'hDEAD);
    @(posedge clk); #2;
    chk("stray_proto", proto_err, 1'b1);
    chk("stray_novalid", wb_valid, 1'b0);
    idle();
    idle();

    // Reset with two entries queued
    drive(1'b0, 1'b1, mk(9, 1, 1, 2, 0, 0, '0, 32'h130), 1'b0, 1'b0, '0);
    drive(1'b0, 1'b1, mk(10, 1, 1, 0, 0, 1, '0, 32'h134), 1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, nil_e, 1'b0, 1'b0, '0);
    @(posedge clk); #2;
    chk("rst_outs", {wb_valid, wb_wa, wb_wreg, wb_wd, wb_pc, busy, proto_err}, '0);

    // Random traffic under protocol
    for (int n = 0; n < 800; n++) begin
      fl  = ($urandom_range(0, 19) == 0) && (m_drop == 0);
      dok = ((m_drop + m_unfilled()) > 0) && ($urandom_range(0, 1) == 1);
      drive(($urandom_range(0, 249) == 0), ($urandom_range(0, 2) != 0),
            mk($urandom_range(0, 31), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 2), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
               $urandom(), $urandom()),
            fl, dok, $urandom());
    end

    // Drain
    guard = 0;
    while ((mq.size() > 0 || m_drop > 0) && guard < 100) begin
      drive(1'b0, 1'b0, nil_e, 1'b0, ((m_drop + m_unfilled()) > 0), $urandom());
      guard++;
    end
    chk("drain_timeout", guard < 100, 1'b1);
    idle();
    idle();
    @(posedge clk); #2;
    chk("exp_q_empty", exp_q.size(), 0);

    // Wide datapath alignment
    x_load("lw64_off4", 2, 1'b0, 4, 64'h8000000100000000, 64'hFFFFFFFF80000001);
    x_load("lbu64_off7", 0, 1'b1, 7, 64'hAB00000000000000, 64'h00000000000000AB);
    x_load("ld64", 3, 1'b0, 5, 64'h8123456789ABCDEF, 64'h8123456789ABCDEF);
    x_load("lh64_off6", 1, 1'b0, 7, 64'h9876000000000000, 64'hFFFFFFFFFFFF9876);
    chk("x_proto", x_proto, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
